// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, operator and state encodings for the keypad calculator
package calc_pkg;

    localparam logic [3:0] KEY_PLUS  = 4'hA;
    localparam logic [3:0] KEY_MINUS = 4'hB;
    localparam logic [3:0] KEY_MUL   = 4'hC;
    localparam logic [3:0] KEY_DIV   = 4'hD;
    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] KEY_DP    = 4'hF;

    typedef enum logic [1:0] {OP_PLUS, OP_MINUS, OP_MUL, OP_DIV} op_e;

    typedef enum logic [2:0] {
        S_CLEAR, S_READ, S_DIGIT, S_DP, S_OP, S_DIV, S_CHECK, S_ERROR
    } state_e;

    // Fixed trip count keeps the loop unrollable when n is not a constant.
    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < 19; i++) begin
            if (i < n) r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/calc_divider.sv
// rtl/calc_divider.sv - unsigned restoring divider, 2W/W, one quotient bit per cycle
module calc_divider #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           done,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [W:0]    trial;

    // Caller guarantees dividend[2W-1:W] < divisor, so the quotient fits in W bits.
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        trial  = {rem_q, quo_q[W-1]};
        if (start) begin
            rem_d = dividend[2*W-1:W];
            quo_d = dividend[W-1:0];
            dvs_d = divisor;
            cnt_d = CW'(W);
        end else if (cnt_q != '0) begin
            if (trial >= {1'b0, dvs_q}) begin
                rem_d = W'(trial - {1'b0, dvs_q});
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = trial[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d  = cnt_q - CW'(1);
            done_d = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/keypad_calc_fx.sv
// rtl/keypad_calc_fx.sv - keypad fixed-point calculator top; CALC_ROUND_HALF_UP_EN rounds mul/div half away from zero
module keypad_calc_fx
    import calc_pkg::*;
#(
    parameter int INT_DIGITS  = 4,
    parameter int FRAC_DIGITS = 3,
    parameter int W           = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    output logic         key_ready,
    output logic [W-1:0] display,
    output logic         error,
    output logic         busy,
    output logic         result_valid
);

    localparam logic [W-1:0]   SCALE    = W'(pow10(FRAC_DIGITS));
    localparam logic [2*W-1:0] SCALE_2W = (2*W)'(pow10(FRAC_DIGITS));
    localparam logic [W-1:0]   LIMIT    = W'(pow10(INT_DIGITS + FRAC_DIGITS) - 64'd1);
    localparam logic [2*W-1:0] LIMIT_2W = (2*W)'(pow10(INT_DIGITS + FRAC_DIGITS) - 64'd1);

    state_e       state_q, state_d;
    op_e          pend_op_q, pend_op_d, new_op_q, new_op_d, key_op;
    logic [W-1:0] mag_q, mag_d, acc_q, acc_d, display_q, display_d;
    logic [7:0]   int_cnt_q, int_cnt_d, frac_cnt_q, frac_cnt_d;
    logic [3:0]   key_q, key_d;
    logic         neg_q, neg_d, dp_q, dp_d, div_neg_q, div_neg_d;
    logic         error_q, error_d, result_valid_q, result_valid_d;
    logic         go_err;

    logic [W-1:0]   opnd, acc_mag, digit_w, int_mag, frac_mag;
    logic [2*W-1:0] prod, mul_mag, mul_res, div_dividend;
    logic           mul_neg, div_ovf, div_start, div_done;
    logic [W-1:0]   div_quo, div_rem;
    logic [W:0]     div_res;

    assign opnd     = neg_q ? -mag_q : mag_q;
    assign acc_mag  = acc_q[W-1] ? -acc_q : acc_q;
    assign digit_w  = {{(W-4){1'b0}}, key_q};
    assign int_mag  = mag_q * W'(10) + digit_w * SCALE;
    assign frac_mag = mag_q + digit_w * W'(pow10(FRAC_DIGITS - 1 - int'(frac_cnt_q)));

    // Low 2W bits of the sign-extended product equal the signed product.
    assign prod    = {{W{acc_q[W-1]}}, acc_q} * {{W{opnd[W-1]}}, opnd};
    assign mul_neg = prod[2*W-1];
    assign mul_mag = mul_neg ? -prod : prod;

    assign div_dividend = {{W{1'b0}}, acc_mag} * SCALE_2W;
    assign div_ovf      = div_dividend[2*W-1:W] >= mag_q;
    assign div_start    = (state_q == S_OP) && (pend_op_q == OP_DIV) && (mag_q != '0) && !div_ovf;

`ifdef CALC_ROUND_HALF_UP_EN
    assign mul_res = (mul_mag + (SCALE_2W >> 1)) / SCALE_2W;
    assign div_res = {1'b0, div_quo} + (({div_rem, 1'b0} >= {1'b0, mag_q}) ? (W+1)'(1) : (W+1)'(0));
`else
    assign mul_res = mul_mag / SCALE_2W;
    assign div_res = {1'b0, div_quo};
`endif

    calc_divider #(.W(W)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (mag_q),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        case (key_code)
            KEY_MINUS: key_op = OP_MINUS;
            KEY_MUL:   key_op = OP_MUL;
            KEY_DIV:   key_op = OP_DIV;
            default:   key_op = OP_PLUS;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        pend_op_d      = pend_op_q;
        new_op_d       = new_op_q;
        mag_d          = mag_q;
        acc_d          = acc_q;
        display_d      = display_q;
        int_cnt_d      = int_cnt_q;
        frac_cnt_d     = frac_cnt_q;
        key_d          = key_q;
        neg_d          = neg_q;
        dp_d           = dp_q;
        div_neg_d      = div_neg_q;
        error_d        = error_q;
        result_valid_d = 1'b0;
        go_err         = 1'b0;
        case (state_q)
            S_CLEAR: begin
                mag_d      = '0;
                acc_d      = '0;
                display_d  = '0;
                int_cnt_d  = '0;
                frac_cnt_d = '0;
                neg_d      = 1'b0;
                dp_d       = 1'b0;
                error_d    = 1'b0;
                pend_op_d  = OP_PLUS;
                state_d    = S_READ;
            end
            S_READ: if (key_valid) begin
                key_d = key_code;
                if (key_code <= 4'd9) state_d = S_DIGIT;
                else if (key_code == KEY_DP) state_d = S_DP;
                else if (key_code == KEY_CLEAR) state_d = S_CLEAR;
                else if (key_code == KEY_MINUS && int_cnt_q == '0 && frac_cnt_q == '0 && !dp_q)
                    neg_d = 1'b1;
                else begin
                    new_op_d = key_op;
                    state_d  = S_OP;
                end
            end
            S_DIGIT: begin
                state_d = S_READ;
                if (!dp_q && int_cnt_q < 8'(INT_DIGITS)) begin
                    mag_d     = int_mag;
                    int_cnt_d = int_cnt_q + 8'd1;
                end else if (dp_q && frac_cnt_q < 8'(FRAC_DIGITS)) begin
                    mag_d      = frac_mag;
                    frac_cnt_d = frac_cnt_q + 8'd1;
                end else go_err = 1'b1;
                display_d = neg_q ? -mag_d : mag_d;
            end
            S_DP: begin
                state_d = S_READ;
                if (dp_q) go_err = 1'b1;
                else dp_d = 1'b1;
            end
            S_OP: begin
                pend_op_d = new_op_q;
                state_d   = S_CHECK;
                case (pend_op_q)
                    OP_PLUS:  acc_d = acc_q + opnd;
                    OP_MINUS: acc_d = acc_q - opnd;
                    OP_MUL: begin
                        if (mul_res > LIMIT_2W) go_err = 1'b1;
                        else acc_d = mul_neg ? W'(-mul_res) : W'(mul_res);
                    end
                    default: begin
                        if (mag_q == '0 || div_ovf) go_err = 1'b1;
                        else begin
                            div_neg_d = acc_q[W-1] ^ neg_q;
                            state_d   = S_DIV;
                        end
                    end
                endcase
            end
            S_DIV: if (div_done) begin
                state_d = S_CHECK;
                if (div_res > {1'b0, LIMIT}) go_err = 1'b1;
                else acc_d = div_neg_q ? W'(-div_res) : W'(div_res);
            end
            S_CHECK: begin
                if (acc_mag > LIMIT) go_err = 1'b1;
                else begin
                    display_d      = acc_q;
                    result_valid_d = 1'b1;
                    mag_d          = '0;
                    int_cnt_d      = '0;
                    frac_cnt_d     = '0;
                    neg_d          = 1'b0;
                    dp_d           = 1'b0;
                    state_d        = S_READ;
                end
            end
            S_ERROR: if (key_valid && key_code == KEY_CLEAR) begin
                error_d = 1'b0;
                state_d = S_CLEAR;
            end
            default: state_d = S_CLEAR;
        endcase
        if (go_err) begin
            state_d   = S_ERROR;
            error_d   = 1'b1;
            display_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_CLEAR;
            pend_op_q      <= OP_PLUS;
            new_op_q       <= OP_PLUS;
            mag_q          <= '0;
            acc_q          <= '0;
            display_q      <= '0;
            int_cnt_q      <= '0;
            frac_cnt_q     <= '0;
            key_q          <= '0;
            neg_q          <= 1'b0;
            dp_q           <= 1'b0;
            div_neg_q      <= 1'b0;
            error_q        <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pend_op_q      <= pend_op_d;
            new_op_q       <= new_op_d;
            mag_q          <= mag_d;
            acc_q          <= acc_d;
            display_q      <= display_d;
            int_cnt_q      <= int_cnt_d;
            frac_cnt_q     <= frac_cnt_d;
            key_q          <= key_d;
            neg_q          <= neg_d;
            dp_q           <= dp_d;
            div_neg_q      <= div_neg_d;
            error_q        <= error_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign key_ready    = (state_q == S_READ) || (state_q == S_ERROR);
    assign busy         = (state_q == S_DIV);
    assign display      = display_q;
    assign error        = error_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_keypad_calc_fx.sv
// tb/tb_keypad_calc_fx.sv - directed self-checking bench for keypad_calc_fx
module tb_keypad_calc_fx;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic [3:0]   key_code = 4'h0;
    logic         key_ready, error, busy, result_valid;
    logic [W-1:0] display;

    int n_checks = 0;
    int n_errors = 0;
    int rv_cnt = 0;

    keypad_calc_fx #(.INT_DIGITS(4), .FRAC_DIGITS(3), .W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ready    (key_ready),
        .display      (display),
        .error        (error),
        .busy         (busy),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (result_valid) rv_cnt++;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (key_ready) return;
        end
        check("ready_timeout", 0, 1);
    endtask

    task automatic send_key(input logic [3:0] k);
        wait_ready();
        key_code  = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic keys(input string s);
        logic [3:0] k;
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "+":     k = 4'hA;
                "-":     k = 4'hB;
                "*":     k = 4'hC;
                "/":     k = 4'hD;
                "c":     k = 4'hE;
                ".":     k = 4'hF;
                default: k = 4'(s[i] - 8'h30);
            endcase
            send_key(k);
        end
        wait_ready();
    endtask

    int lat, busy_cnt, rdy_bad;
    logic [W-1:0] disp_cap;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_display", $signed(display), 0);
        check("rst_error", error, 0);
        check("rst_busy", busy, 0);
        check("rst_rv", result_valid, 0);
        check("rst_ready", key_ready, 0);
        rst_n = 1'b1;

        rv_cnt = 0;
        keys("12.5");
        check("entry_12.5", $signed(display), 12500);
        check("entry_no_rv", rv_cnt, 0);

        keys("c12+");
        check("add_first", $signed(display), 12000);
        keys("3");
        send_key(4'hA);
        @(posedge clk); #1;
        check("add_rv_cyc1", result_valid, 0);
        @(posedge clk); #1;
        check("add_rv_cyc2", result_valid, 1);
        check("add_result", $signed(display), 15000);

        keys("c-2*3+");
        check("neg_mul", $signed(display), -6000);
        keys("c5-8+");
        check("sub_neg", $signed(display), -3000);
        keys("c1.5*.5+");
        check("frac_mul", $signed(display), 750);

        keys("c2/3");
        send_key(4'hA);
        key_code  = 4'h4;
        key_valid = 1'b1;
        lat = 0; busy_cnt = 0; rdy_bad = 0; disp_cap = '0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (lat != 0) break;
            if (busy) busy_cnt++;
            if (busy && key_ready) rdy_bad++;
            if (result_valid) begin
                lat = c;
                disp_cap = display;
            end
        end
        key_valid = 1'b0;
        check("div_latency", lat, W + 3);
        check("div_busy_cycles", busy_cnt, W + 1);
        check("div_ready_low", rdy_bad, 0);
`ifdef CALC_ROUND_HALF_UP_EN
        check("div_result", $signed(disp_cap), 667);
`else
        check("div_result", $signed(disp_cap), 666);
`endif
        wait_ready();
        check("held_key_kept", $signed(display), 4000);

        keys("c5/0+");
        check("div0_error", error, 1);
        check("div0_display", $signed(display), 0);
        keys("7");
        check("err_ignore_error", error, 1);
        check("err_ignore_display", $signed(display), 0);
        keys("c");
        check("err_clear_error", error, 0);
        check("err_clear_display", $signed(display), 0);

        keys("9999*");
        check("big_operand", $signed(display), 9999000);
        keys("2+");
        check("mul_overflow", error, 1);

        keys("c1234");
        check("four_digits", $signed(display), 1234000);
        check("four_digits_ok", error, 0);
        keys("5");
        check("fifth_digit", error, 1);

        keys("c1.123");
        check("three_frac", $signed(display), 1123);
        keys("4");
        check("fourth_frac", error, 1);

        keys("c1..");
        check("second_dp", error, 1);

        keys("c2/3");
        send_key(4'hA);
        repeat (5) @(posedge clk);
        #1;
        check("mid_div_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_display", $signed(display), 0);
        check("abort_error", error, 0);
        check("abort_busy", busy, 0);
        check("abort_rv", result_valid, 0);
        check("abort_ready", key_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        keys("1+1+");
        check("after_abort", $signed(display), 2000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
